// File: rtl/fifo_drain_arbiter.sv
// Round-robin burst scheduler draining NUM_CHAN FIFO read ports into one
// ready/valid sink through a latency tracker and a credit-limited output queue.
module fifo_drain_arbiter #(
  parameter int unsigned NUM_CHAN   = 4,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned QDEPTH     = 4,
  localparam int unsigned SIZE_BITS = $clog2(DEPTH) + 1,
  localparam int unsigned CHAN_BITS = $clog2(NUM_CHAN)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CHAN-1:0]           chan_enable,
  input  logic [NUM_CHAN*SIZE_BITS-1:0] fifo_size,
  output logic [NUM_CHAN-1:0]           fifo_rd_en,
  input  logic [NUM_CHAN*WIDTH-1:0]     fifo_rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [CHAN_BITS-1:0]          out_chan,
  output logic                          out_last,
  output logic                          busy
);

  localparam int unsigned BL_BITS   = $clog2(MAX_BURST + 1);
  localparam int unsigned CMP_BITS  = (SIZE_BITS > BL_BITS) ? SIZE_BITS : BL_BITS;
  localparam int unsigned QPTR_BITS = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned QCNT_BITS = $clog2(QDEPTH + 1);
  localparam int unsigned INF_BITS  = $clog2(RD_LATENCY + 1);
  localparam int unsigned CRD_BITS  = $clog2(QDEPTH + RD_LATENCY + 1);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t                 r_state, w_state_nxt;
  logic [CHAN_BITS-1:0]   r_grant, w_grant_nxt;
  logic [CHAN_BITS-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [BL_BITS-1:0]     r_burst_left, w_burst_left_nxt;

  logic [SIZE_BITS-1:0]   w_size [NUM_CHAN];
  logic [WIDTH-1:0]       w_rd_data [NUM_CHAN];

  logic                   w_found;
  logic [CHAN_BITS-1:0]   w_pick;
  logic [SIZE_BITS-1:0]   w_pick_size;
  logic [BL_BITS-1:0]     w_burst_init;

  logic                   w_credit_ok;
  logic                   w_strobe;
  logic                   w_strobe_last;

  logic                   r_tv [RD_LATENCY];
  logic [CHAN_BITS-1:0]   r_tc [RD_LATENCY];
  logic                   r_tl [RD_LATENCY];
  logic [INF_BITS-1:0]    w_inflight;

  logic [WIDTH-1:0]       r_qdata [QDEPTH];
  logic [CHAN_BITS-1:0]   r_qchan [QDEPTH];
  logic                   r_qlast [QDEPTH];
  logic [QPTR_BITS-1:0]   r_wptr, r_rptr;
  logic [QCNT_BITS-1:0]   r_qcount;
  logic                   w_push, w_pop;

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_unpack
    assign w_size[c]    = fifo_size[c*SIZE_BITS +: SIZE_BITS];
    assign w_rd_data[c] = fifo_rd_data[c*WIDTH +: WIDTH];
  end

  function automatic logic [QPTR_BITS-1:0] qptr_inc(input logic [QPTR_BITS-1:0] p);
    return (p == QPTR_BITS'(QDEPTH - 1)) ? '0 : p + QPTR_BITS'(1);
  endfunction

  // Rotating search from r_rr_ptr; the first eligible channel in wrap order wins.
  always_comb begin
    logic [CHAN_BITS:0]  v_sum;
    logic [CHAN_BITS-1:0] v_idx;
    logic [CMP_BITS-1:0] v_sz;
    w_found     = 1'b0;
    w_pick      = '0;
    w_pick_size = '0;
    v_sum       = '0;
    v_idx       = '0;
    for (int unsigned i = 0; i < NUM_CHAN; i++) begin
      v_sum = {1'b0, r_rr_ptr} + (CHAN_BITS+1)'(i);
      if (v_sum >= (CHAN_BITS+1)'(NUM_CHAN)) v_sum = v_sum - (CHAN_BITS+1)'(NUM_CHAN);
      v_idx = v_sum[CHAN_BITS-1:0];
      if (!w_found && chan_enable[v_idx] && (w_size[v_idx] != '0)) begin
        w_found     = 1'b1;
        w_pick      = v_idx;
        w_pick_size = w_size[v_idx];
      end
    end
    v_sz         = CMP_BITS'(w_pick_size);
    w_burst_init = (v_sz < CMP_BITS'(MAX_BURST)) ? BL_BITS'(v_sz) : BL_BITS'(MAX_BURST);
  end

  assign w_credit_ok = (CRD_BITS'(r_qcount) + CRD_BITS'(w_inflight)) < CRD_BITS'(QDEPTH);

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_burst_left_nxt = r_burst_left;
    w_strobe         = 1'b0;
    w_strobe_last    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt      = w_pick;
          w_burst_left_nxt = w_burst_init;
          w_rr_ptr_nxt     = (w_pick == CHAN_BITS'(NUM_CHAN - 1)) ? '0 : w_pick + CHAN_BITS'(1);
          w_state_nxt      = ST_BURST;
        end
      end
      ST_BURST: begin
        if (w_credit_ok) begin
          w_strobe         = 1'b1;
          w_burst_left_nxt = r_burst_left - BL_BITS'(1);
          if (r_burst_left == BL_BITS'(1)) begin
            w_strobe_last = 1'b1;
            w_state_nxt   = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = '0;
    if (w_strobe) fifo_rd_en[r_grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_burst_left <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_burst_left <= w_burst_left_nxt;
    end
  end

  // Stage RD_LATENCY-1 lines up with the cycle the FIFO presents the read word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        r_tv[i] <= 1'b0;
        r_tc[i] <= '0;
        r_tl[i] <= 1'b0;
      end
    end else begin
      r_tv[0] <= w_strobe;
      r_tc[0] <= r_grant;
      r_tl[0] <= w_strobe_last;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        r_tv[i] <= r_tv[i-1];
        r_tc[i] <= r_tc[i-1];
        r_tl[i] <= r_tl[i-1];
      end
    end
  end

  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + INF_BITS'(r_tv[i]);
    end
  end

  assign w_push = r_tv[RD_LATENCY-1];
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        r_qdata[i] <= '0;
        r_qchan[i] <= '0;
        r_qlast[i] <= 1'b0;
      end
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_qcount <= '0;
    end else begin
      if (w_push) begin
        r_qdata[r_wptr] <= w_rd_data[r_tc[RD_LATENCY-1]];
        r_qchan[r_wptr] <= r_tc[RD_LATENCY-1];
        r_qlast[r_wptr] <= r_tl[RD_LATENCY-1];
        r_wptr          <= qptr_inc(r_wptr);
      end
      if (w_pop) r_rptr <= qptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_qcount <= r_qcount + QCNT_BITS'(1);
        2'b01:   r_qcount <= r_qcount - QCNT_BITS'(1);
        default: r_qcount <= r_qcount;
      endcase
    end
  end

  assign out_valid = (r_qcount != '0);
  assign out_data  = out_valid ? r_qdata[r_rptr] : '0;
  assign out_chan  = out_valid ? r_qchan[r_rptr] : '0;
  assign out_last  = out_valid ? r_qlast[r_rptr] : 1'b0;
  assign busy      = (r_state != ST_IDLE) || (w_inflight != '0) || (r_qcount != '0);

endmodule
